// File: rtl/prec_conv_stream_pkg.sv
// Shared types and helpers for the precision-converter stream.
// dconf_t describes a fixed-point format: .prec is the bit width, .sign selects
// two's-complement interpretation. conf_max/conf_min give the representable
// range of a format as a wide signed value, so comparisons never overflow.
package prec_conv_stream_pkg;

  typedef struct packed {
    logic       sign;
    logic [7:0] prec;
  } dconf_t;

  localparam dconf_t DEF_DCONF_INT  = '{sign: 1'b1, prec: 8'd8};
  localparam dconf_t DEF_DCONFL_INT = '{sign: 1'b1, prec: 8'd16};

  // Wide enough to hold any 64-bit signed or unsigned value plus a guard bit.
  localparam int unsigned LimW = 66;
  typedef logic signed [LimW-1:0] lim_t;

  function automatic lim_t conf_max(dconf_t c);
    lim_t one;
    one = lim_t'(1);
    if (c.sign) return (one << (c.prec - 8'd1)) - one;
    else        return (one << c.prec) - one;
  endfunction

  function automatic lim_t conf_min(dconf_t c);
    lim_t one;
    one = lim_t'(1);
    if (c.sign) return -(one << (c.prec - 8'd1));
    else        return '0;
  endfunction

endpackage

// File: rtl/prec_conv_stream_if.sv
// Valid/ready stream bundle for prec_conv_stream.
//   in_*  : upstream beat (LANES lanes of I_PREC bits) and its ready
//   out_* : converted beat (LANES lanes of O_PREC bits), per-lane overflow flags
// master: the side that produces input beats and consumes output beats.
// slave : the converter itself.
interface prec_conv_stream_if #(
  parameter int unsigned LANES  = 4,
  parameter int unsigned I_PREC = 8,
  parameter int unsigned O_PREC = 16
);
  logic [LANES*I_PREC-1:0] in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*O_PREC-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES-1:0]        out_ovf;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_ovf
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_ovf
  );
endinterface

// File: rtl/prec_conv_lane.sv
// Single-lane combinational fixed-point converter.
//   val_i : input value in I_CONF format
//   val_o : value in O_CONF format (clamped when SAT_EN, else low bits kept)
//   ovf_o : input was outside the representable output range
module prec_conv_lane
  import prec_conv_stream_pkg::*;
#(
  parameter dconf_t      I_CONF = DEF_DCONF_INT,
  parameter dconf_t      O_CONF = DEF_DCONFL_INT,
  parameter bit          SAT_EN = 1'b1,
  parameter int unsigned I_PREC = I_CONF.prec,
  parameter int unsigned O_PREC = O_CONF.prec
) (
  input  logic [I_PREC-1:0] val_i,
  output logic [O_PREC-1:0] val_o,
  output logic              ovf_o
);

  localparam lim_t Hi = conf_max(O_CONF);
  localparam lim_t Lo = conf_min(O_CONF);

  lim_t val;
  logic over;
  logic under;

  always_comb begin
    // Bring the input into the wide signed domain so range checks are exact.
    if (I_CONF.sign) val = lim_t'({{(LimW-I_PREC){val_i[I_PREC-1]}}, val_i});
    else             val = lim_t'({{(LimW-I_PREC){1'b0}}, val_i});
    over  = (val > Hi);
    under = (val < Lo);
    ovf_o = over | under;
    val_o = val[O_PREC-1:0];
    if (SAT_EN) begin
      if (over)       val_o = Hi[O_PREC-1:0];
      else if (under) val_o = Lo[O_PREC-1:0];
    end
  end

endmodule

// File: rtl/prec_conv_stream.sv
// Multi-lane pipelined precision converter with a 2-entry output buffer.
//   clk, reset_ : clock, asynchronous active-low reset
//   s           : stream bundle (slave side); conversion happens at push time
//   sat_cnt     : saturating count of lane overflow events on pushed beats
//   cnt_clr     : synchronous clear of sat_cnt, wins over same-edge events
module prec_conv_stream
  import prec_conv_stream_pkg::*;
#(
  parameter dconf_t      I_CONF = DEF_DCONF_INT,
  parameter dconf_t      O_CONF = DEF_DCONFL_INT,
  parameter int unsigned LANES  = 4,
  parameter bit          SAT_EN = 1'b1,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned I_PREC = I_CONF.prec,
  parameter int unsigned O_PREC = O_CONF.prec
) (
  input  logic               clk,
  input  logic               reset_,
  prec_conv_stream_if.slave  s,
  output logic [CNT_W-1:0]   sat_cnt,
  input  logic               cnt_clr
);

  localparam int unsigned      SumW   = CNT_W + $clog2(LANES + 1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [LANES*O_PREC-1:0] conv_data;
  logic [LANES-1:0]        conv_ovf;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    prec_conv_lane #(
      .I_CONF (I_CONF),
      .O_CONF (O_CONF),
      .SAT_EN (SAT_EN)
    ) u_lane (
      .val_i (s.in_data[i*I_PREC +: I_PREC]),
      .val_o (conv_data[i*O_PREC +: O_PREC]),
      .ovf_o (conv_ovf[i])
    );
  end

  logic [LANES*O_PREC-1:0] data_q [2];
  logic [LANES*O_PREC-1:0] data_d [2];
  logic [LANES-1:0]        ovf_q  [2];
  logic [LANES-1:0]        ovf_d  [2];
  logic                    wr_ptr_q, wr_ptr_d;
  logic                    rd_ptr_q, rd_ptr_d;
  logic [1:0]              count_q, count_d;
  logic                    in_ready_q, in_ready_d;
  logic [CNT_W-1:0]        sat_cnt_q, sat_cnt_d;
  logic [SumW-1:0]         sum;
  logic                    push;
  logic                    pop;

  assign push = s.in_valid & in_ready_q;
  assign pop  = (count_q != 2'd0) & s.out_ready;

  always_comb begin
    data_d   = data_q;
    ovf_d    = ovf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      data_d[wr_ptr_q] = conv_data;
      ovf_d[wr_ptr_q]  = conv_ovf;
      wr_ptr_d         = ~wr_ptr_q;
    end
    if (pop) rd_ptr_d = ~rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    // Registered ready: decided one cycle ahead from the next occupancy, so
    // there is no combinational path from out_ready to in_ready.
    in_ready_d = (count_d != 2'd2);
  end

  always_comb begin
    sum = SumW'(sat_cnt_q);
    for (int i = 0; i < LANES; i++) sum = sum + SumW'(conv_ovf[i]);
    sat_cnt_d = sat_cnt_q;
    if (cnt_clr)   sat_cnt_d = '0;
    else if (push) sat_cnt_d = (sum > SumW'(CntMax)) ? CntMax : sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        ovf_q[i]  <= '0;
      end
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      in_ready_q <= 1'b0;
      sat_cnt_q  <= '0;
    end else begin
      data_q     <= data_d;
      ovf_q      <= ovf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      in_ready_q <= in_ready_d;
      sat_cnt_q  <= sat_cnt_d;
    end
  end

  assign s.in_ready  = in_ready_q;
  assign s.out_valid = (count_q != 2'd0);
  assign s.out_data  = s.out_valid ? data_q[rd_ptr_q] : '0;
  assign s.out_ovf   = s.out_valid ? ovf_q[rd_ptr_q] : '0;
  assign sat_cnt     = sat_cnt_q;

endmodule

// File: tb/tb_prec_conv_stream.sv
module tb_prec_conv_stream;
  import prec_conv_stream_pkg::*;

  localparam dconf_t S8  = '{sign: 1'b1, prec: 8'd8};
  localparam dconf_t S16 = '{sign: 1'b1, prec: 8'd16};
  localparam dconf_t U8  = '{sign: 1'b0, prec: 8'd8};

  logic        clk = 1'b0;
  logic        reset_;
  logic        clr_a, clr_b, clr_c, clr_d;
  logic [15:0] cnt_a, cnt_c, cnt_d;
  logic [3:0]  cnt_b;

  always #5 clk = ~clk;

  prec_conv_stream_if #(.LANES(4), .I_PREC(8),  .O_PREC(16)) if_a ();
  prec_conv_stream_if #(.LANES(4), .I_PREC(16), .O_PREC(8))  if_b ();
  prec_conv_stream_if #(.LANES(4), .I_PREC(16), .O_PREC(8))  if_c ();
  prec_conv_stream_if #(.LANES(4), .I_PREC(8),  .O_PREC(8))  if_d ();

  prec_conv_stream #(.I_CONF(S8), .O_CONF(S16), .LANES(4), .SAT_EN(1'b1), .CNT_W(16)) u_a (
    .clk(clk), .reset_(reset_), .s(if_a), .sat_cnt(cnt_a), .cnt_clr(clr_a));
  prec_conv_stream #(.I_CONF(S16), .O_CONF(S8), .LANES(4), .SAT_EN(1'b1), .CNT_W(4)) u_b (
    .clk(clk), .reset_(reset_), .s(if_b), .sat_cnt(cnt_b), .cnt_clr(clr_b));
  prec_conv_stream #(.I_CONF(S16), .O_CONF(S8), .LANES(4), .SAT_EN(1'b0), .CNT_W(16)) u_c (
    .clk(clk), .reset_(reset_), .s(if_c), .sat_cnt(cnt_c), .cnt_clr(clr_c));
  prec_conv_stream #(.I_CONF(S8), .O_CONF(U8), .LANES(4), .SAT_EN(1'b1), .CNT_W(16)) u_d (
    .clk(clk), .reset_(reset_), .s(if_d), .sat_cnt(cnt_d), .cnt_clr(clr_d));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int d, input logic v, input logic [63:0] din);
    case (d)
      0: begin if_a.in_valid = v; if_a.in_data = din[31:0]; end
      1: begin if_b.in_valid = v; if_b.in_data = din;       end
      2: begin if_c.in_valid = v; if_c.in_data = din;       end
      default: begin if_d.in_valid = v; if_d.in_data = din[31:0]; end
    endcase
  endtask

  task automatic sample(input int d, output logic v, output logic r,
                        output logic [63:0] dat, output logic [3:0] ov);
    case (d)
      0: begin v = if_a.out_valid; r = if_a.in_ready; dat = if_a.out_data;        ov = if_a.out_ovf; end
      1: begin v = if_b.out_valid; r = if_b.in_ready; dat = {32'h0, if_b.out_data}; ov = if_b.out_ovf; end
      2: begin v = if_c.out_valid; r = if_c.in_ready; dat = {32'h0, if_c.out_data}; ov = if_c.out_ovf; end
      default: begin v = if_d.out_valid; r = if_d.in_ready; dat = {32'h0, if_d.out_data}; ov = if_d.out_ovf; end
    endcase
  endtask

  typedef struct {
    int          dut;
    logic [63:0] din;
    logic [63:0] dout;
    logic [3:0]  ovf;
  } vec_t;

  vec_t        vecs [8];
  logic        v, r;
  logic [63:0] dat;
  logic [3:0]  ov;

  initial begin
    // Lane 0 sits in the least significant bits.
    vecs[0] = '{0, 64'h0000_0000_FF00_7F80, 64'hFFFF_0000_007F_FF80, 4'b0000};
    vecs[1] = '{0, 64'h0000_0000_01FE_40C0, 64'h0001_FFFE_0040_FFC0, 4'b0000};
    vecs[2] = '{1, 64'h8000_0042_FF00_0123, 64'h0000_0000_8042_807F, 4'b1011};
    vecs[3] = '{1, 64'h0000_FFFF_007F_FF80, 64'h0000_0000_00FF_7F80, 4'b0000};
    vecs[4] = '{1, 64'hFFFF_7FFF_FF7F_0080, 64'h0000_0000_FF7F_807F, 4'b0111};
    vecs[5] = '{2, 64'h8000_0042_FF00_0123, 64'h0000_0000_0042_0023, 4'b1011};
    vecs[6] = '{2, 64'hFF7F_FF80_0100_00FF, 64'h0000_0000_7F80_00FF, 4'b1011};
    vecs[7] = '{3, 64'h0000_0000_7F80_05FB, 64'h0000_0000_7F00_0500, 4'b0101};

    reset_ = 1'b1;
    clr_a = 1'b0; clr_b = 1'b0; clr_c = 1'b0; clr_d = 1'b0;
    for (int d = 0; d < 4; d++) drive(d, 1'b0, 64'h0);
    if_a.out_ready = 1'b1; if_b.out_ready = 1'b1;
    if_c.out_ready = 1'b1; if_d.out_ready = 1'b1;
    #1 reset_ = 1'b0;
    #1;
    check("rst_out_valid", 64'(if_a.out_valid), 64'h0);
    check("rst_out_data", if_a.out_data, 64'h0);
    check("rst_out_ovf", 64'(if_b.out_ovf), 64'h0);
    check("rst_sat_cnt", 64'(cnt_b), 64'h0);
    #10 reset_ = 1'b1;
    step();
    check("in_ready_after_release", 64'(if_a.in_ready), 64'h1);

    // Table-driven conversions, one beat per vector, latency 1.
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].dut, 1'b1, vecs[i].din);
      step();
      sample(vecs[i].dut, v, r, dat, ov);
      check($sformatf("vec%0d_valid", i), 64'(v), 64'h1);
      check($sformatf("vec%0d_data", i), dat, vecs[i].dout);
      check($sformatf("vec%0d_ovf", i), 64'(ov), 64'(vecs[i].ovf));
      drive(vecs[i].dut, 1'b0, 64'h0);
    end
    step();
    check("sat_cnt_b", 64'(cnt_b), 64'd6);
    check("sat_cnt_c", 64'(cnt_c), 64'd6);
    check("sat_cnt_d", 64'(cnt_d), 64'd2);
    check("sat_cnt_a", 64'(cnt_a), 64'd0);
    check("drained_b", 64'(if_b.out_valid), 64'h0);

    // Saturating counter, CNT_W=4, four overflowing lanes per beat.
    clr_b = 1'b1;
    step();
    clr_b = 1'b0;
    check("cnt_clr_alone", 64'(cnt_b), 64'd0);
    drive(1, 1'b1, 64'h8000_8000_8000_8000);
    step(); step(); step();
    check("cnt_12", 64'(cnt_b), 64'd12);
    step(); step();
    check("cnt_sat_15", 64'(cnt_b), 64'd15);
    clr_b = 1'b1;
    step();
    check("cnt_clr_with_push", 64'(cnt_b), 64'd0);
    clr_b = 1'b0;
    step();
    check("cnt_after_clr_push", 64'(cnt_b), 64'd4);
    drive(1, 1'b0, 64'h0);
    step();

    // Backpressure: fill the buffer, then drain in order.
    if_a.out_ready = 1'b0;
    drive(0, 1'b1, 64'h11);
    step();
    check("bp_ready_one", 64'(if_a.in_ready), 64'h1);
    check("bp_head_a", if_a.out_data, 64'h11);
    drive(0, 1'b1, 64'h22);
    step();
    drive(0, 1'b0, 64'h0);
    check("bp_ready_full", 64'(if_a.in_ready), 64'h0);
    check("bp_head_a_full", if_a.out_data, 64'h11);
    step();
    check("bp_stable", if_a.out_data, 64'h11);
    check("bp_still_full", 64'(if_a.in_ready), 64'h0);
    if_a.out_ready = 1'b1;
    step();
    check("bp_second_b", if_a.out_data, 64'h22);
    check("bp_valid_b", 64'(if_a.out_valid), 64'h1);
    step();
    check("bp_empty", 64'(if_a.out_valid), 64'h0);

    // Streaming at one beat per cycle.
    for (int k = 1; k <= 10; k++) begin
      drive(0, 1'b1, 64'(k));
      step();
      check($sformatf("stream%0d_data", k), if_a.out_data, 64'(k));
      check($sformatf("stream%0d_ready", k), 64'(if_a.in_ready), 64'h1);
    end
    drive(0, 1'b0, 64'h0);
    step();
    check("stream_drained", 64'(if_a.out_valid), 64'h0);

    // Asynchronous reset with a full buffer.
    if_a.out_ready = 1'b0;
    drive(0, 1'b1, 64'h33);
    step();
    drive(0, 1'b1, 64'h44);
    step();
    drive(0, 1'b0, 64'h0);
    check("rst_full_before", 64'(if_a.in_ready), 64'h0);
    #3 reset_ = 1'b0;
    #1;
    check("rst_mid_valid", 64'(if_a.out_valid), 64'h0);
    check("rst_mid_data", if_a.out_data, 64'h0);
    check("rst_mid_cnt", 64'(cnt_b), 64'h0);
    #2 reset_ = 1'b1;
    if_a.out_ready = 1'b1;
    step();
    check("post_rst_valid", 64'(if_a.out_valid), 64'h0);
    check("post_rst_ready", 64'(if_a.in_ready), 64'h1);
    step();
    check("post_rst_no_stale", 64'(if_a.out_valid), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/prec_conv_stream.md
Name: prec_conv_stream

Overview:
- Multi-lane, pipelined fixed-point precision converter for the perceptron datapath.
- Widens with sign/zero extension, or narrows with saturation or truncation, between any two dconf_t formats.
- Data moves on a valid/ready stream through a 2-entry output buffer.
- Sits between accumulator outputs and activation/storage stages; replaces ad-hoc combinational width adapters where backpressure is needed.

Parameters:
- I_CONF, `DEF_DCONF_INT: input format; .prec gives width, .sign gives signedness.
- O_CONF, `DEF_DCONFL_INT: output format; same fields as I_CONF.
- LANES, 4: number of parallel lanes per beat.
- SAT_EN, 1: 1 = clamp out-of-range values; 0 = keep low O_PREC bits (wrap).
- CNT_W, 16: width of the saturation event counter.
- I_PREC, I_CONF.prec: derived, do not override.
- O_PREC, O_CONF.prec: derived, do not override.

Ports:
- clk  in  1  clock.
- reset_  in  1  asynchronous reset, active-low.
- in_data  in  LANES*I_PREC  lane i occupies bits [i*I_PREC +: I_PREC].
- in_valid  in  1  input beat valid.
- in_ready  out  1  buffer can accept a beat.
- out_data  out  LANES*O_PREC  converted beat, same lane packing.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_ovf  out  LANES  per-lane flag: this beat's lane was clamped or wrapped.
- sat_cnt  out  CNT_W  running count of lane overflow events, saturating.
- cnt_clr  in  1  synchronous clear of sat_cnt.

Behaviour:
- Reset (reset_ low, async):
  - buffer empty; out_valid=0, out_data=0, out_ovf=0, sat_cnt=0.
  - in_ready=1 from the first edge after release.
- Conversion (combinational on in_data, captured at push):
  - Input is interpreted signed iff I_CONF.sign; output is signed iff O_CONF.sign.
  - Output representable range: signed [-2^(O_PREC-1), 2^(O_PREC-1)-1]; unsigned [0, 2^O_PREC-1].
  - In range: value preserved exactly. Widening extends with the input sign bit if signed, else with zeros.
  - Out of range, SAT_EN=1: clamp to the nearest bound, ovf=1.
  - Out of range, SAT_EN=0: low O_PREC bits, ovf=1.
  - Signed input into unsigned output: any negative value is out of range.
  - O_PREC==I_PREC with equal signedness: pass-through, ovf never set.
- Handshake:
  - Push when in_valid&&in_ready; pop when out_valid&&out_ready.
  - in_valid must not depend on in_ready; data is held stable while valid and not accepted.
  - Latency: a beat pushed at edge t is visible on out_* after edge t (1 cycle), if the buffer was empty.
- Buffer: 2-entry FIFO, count 0..2.
  - in_ready = (count<2), driven from a register, with no combinational path from out_ready.
  - out_valid = (count>0).
  - Simultaneous push and pop: count unchanged, full throughput of 1 beat/cycle.
  - Push at count=2 is impossible (in_ready=0). Pop at count=0 is ignored.
  - Order is strictly FIFO; out_data/out_ovf are stable while out_valid&&!out_ready.
- sat_cnt:
  - At each push, add popcount(ovf lanes of the pushed beat); saturate at 2^CNT_W-1.
  - cnt_clr has priority: at an edge with cnt_clr=1, sat_cnt=0 and that edge's events are discarded.
- Reset mid-stream: buffered beats are dropped, no partial output; sat_cnt=0.

Decomposition:
- Shared package (perceptron.svh):
  - the dconf_t typedef as already used;
  - a range-limit helper function (min/max for a given conf).
- One sub-module, prec_conv_lane: a single-lane combinational converter (value -> converted value, ovf).
- Top level: instantiates LANES copies of prec_conv_lane, plus the 2-entry FIFO and sat_cnt logic.

Test Plan:
1. I=8 signed, O=16 signed, LANES=4: in lanes {0x80,0x7F,0x00,0xFF} -> out {0xFF80,0x007F,0x0000,0xFFFF}, ovf=0000, latency 1.
2. I=16 signed, O=8 signed, SAT_EN=1: lanes {0x0123,0xFF00,0x0042,0x8000} -> {0x7F,0x80,0x42,0x80}, ovf=1011, sat_cnt +3.
3. Same formats with SAT_EN=0: 0x0123 -> 0x23, ovf=1. I=8 signed, O=8 unsigned, SAT_EN=1: 0xFB (-5) -> 0x00, ovf=1.
4. Backpressure: hold out_ready=0, push beats A,B -> in_ready=0 after B. Release out_ready -> A then B in consecutive cycles; streaming 10 beats with out_ready=1 gives 1 beat/cycle.
5. sat_cnt with CNT_W=4: 20 overflow events -> holds 15. Assert cnt_clr in the same cycle as a push with ovf -> 0.
6. Assert reset_ low asynchronously with count=2 -> out_valid falls immediately, out_data=0, and no stale beat appears after release.
